// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with ASCII W/R register command parser
module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_CLKS = 5000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uart_rx,
  output logic        o_wr_en,
  output logic [7:0]  o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_rd_req,
  output logic [7:0]  o_rd_addr,
  output logic        o_err,
  output logic [7:0]  o_err_cnt
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [BW-1:0] HALF_BIT = BW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] FULL_BIT = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_STOP, R_WAITHI} r_state_t;
  typedef enum logic [2:0] {P_IDLE, P_ADDR, P_DATA, P_EOL, P_DISCARD} p_state_t;

  r_state_t      r_state;
  p_state_t      p_state;
  logic          rx_meta, rx_sync, rx_prev;
  logic [BW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift, rx_byte;
  logic          rx_valid, frame_err;
  logic          is_wr;
  logic [2:0]    nib_cnt;
  logic [7:0]    addr_sh;
  logic [31:0]   data_sh;
  logic [TW-1:0] to_cnt;

  // Returns {is_hex, nibble}; letters map via low nibble + 9 ('A'/'a' low nibble is 1)
  function automatic logic [4:0] hex_decode(input logic [7:0] c);
    logic [4:0] r;
    r = 5'd0;
    if (c >= 8'h30 && c <= 8'h39)
      r = {1'b1, c[3:0]};
    else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
      r = {1'b1, c[3:0] + 4'd9};
    return r;
  endfunction

  logic [4:0] hex;
  logic       is_term, is_space, is_w, is_r, active;
  logic       byte_err, timeout_hit, err_evt;

  assign hex      = hex_decode(rx_byte);
  assign is_term  = (rx_byte == 8'h0D) || (rx_byte == 8'h0A);
  assign is_space = (rx_byte == 8'h20);
  assign is_w     = (rx_byte == 8'h57) || (rx_byte == 8'h77);
  assign is_r     = (rx_byte == 8'h52) || (rx_byte == 8'h72);
  assign active   = (p_state == P_ADDR) || (p_state == P_DATA) || (p_state == P_EOL);

  assign byte_err = rx_valid && (
      ((p_state == P_IDLE) && !is_w && !is_r && !is_term && !is_space) ||
      (((p_state == P_ADDR) || (p_state == P_DATA)) && !hex[4]) ||
      ((p_state == P_EOL) && !is_term));
  assign timeout_hit = active && !rx_valid && (to_cnt == TO_LAST);
  // Framing, parse and timeout errors that coincide collapse into one event
  assign err_evt = frame_err || byte_err || timeout_hit;

  // Two-flop synchroniser plus previous-sample register for falling-edge detect
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Bit-level receive FSM: mid-bit sampling, LSB first, stop-bit validation
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= R_IDLE;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      rx_shift  <= '0;
      rx_byte   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        R_IDLE: begin
          bit_cnt <= '0;
          if (rx_prev && !rx_sync) r_state <= R_START;
        end
        R_START: begin
          if (bit_cnt == HALF_BIT) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            r_state <= rx_sync ? R_IDLE : R_DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (bit_cnt == FULL_BIT) begin
            bit_cnt  <= '0;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) r_state <= R_STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_STOP: begin
          if (bit_cnt == FULL_BIT) begin
            bit_cnt <= '0;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
              r_state  <= R_IDLE;
            end else begin
              frame_err <= 1'b1;
              r_state   <= R_WAITHI;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        R_WAITHI: if (rx_sync) r_state <= R_IDLE;
        default:  r_state <= R_IDLE;
      endcase
    end
  end

  // Command parser FSM with registered strobes, error pulse and saturating count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p_state   <= P_IDLE;
      is_wr     <= 1'b0;
      nib_cnt   <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      to_cnt    <= '0;
      o_wr_en   <= 1'b0;
      o_wr_addr <= '0;
      o_wr_data <= '0;
      o_rd_req  <= 1'b0;
      o_rd_addr <= '0;
      o_err     <= 1'b0;
      o_err_cnt <= '0;
    end else begin
      o_wr_en  <= 1'b0;
      o_rd_req <= 1'b0;
      o_err    <= err_evt;
      if (err_evt && (o_err_cnt != 8'hFF)) o_err_cnt <= o_err_cnt + 1'b1;
      to_cnt <= (rx_valid || !active) ? '0 : to_cnt + 1'b1;

      if (frame_err) begin
        p_state <= P_DISCARD;
      end else if (timeout_hit) begin
        p_state <= P_IDLE;
      end else if (rx_valid) begin
        case (p_state)
          P_IDLE: begin
            nib_cnt <= '0;
            if (is_w || is_r) begin
              is_wr   <= is_w;
              p_state <= P_ADDR;
            end else if (!is_term && !is_space) begin
              p_state <= P_DISCARD;
            end
          end
          P_ADDR: begin
            if (hex[4]) begin
              addr_sh <= {addr_sh[3:0], hex[3:0]};
              nib_cnt <= nib_cnt + 1'b1;
              if (nib_cnt == 3'd1) begin
                nib_cnt <= '0;
                p_state <= is_wr ? P_DATA : P_EOL;
              end
            end else begin
              p_state <= is_term ? P_IDLE : P_DISCARD;
            end
          end
          P_DATA: begin
            if (hex[4]) begin
              data_sh <= {data_sh[27:0], hex[3:0]};
              nib_cnt <= nib_cnt + 1'b1;
              if (nib_cnt == 3'd7) p_state <= P_EOL;
            end else begin
              p_state <= is_term ? P_IDLE : P_DISCARD;
            end
          end
          P_EOL: begin
            if (is_term) begin
              if (is_wr) begin
                o_wr_en   <= 1'b1;
                o_wr_addr <= addr_sh;
                o_wr_data <= data_sh;
              end else begin
                o_rd_req  <= 1'b1;
                o_rd_addr <= addr_sh;
              end
              p_state <= P_IDLE;
            end else begin
              p_state <= P_DISCARD;
            end
          end
          P_DISCARD: if (is_term) p_state <= P_IDLE;
          default:   p_state <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - scoreboard bench for uart_cmd_rx
module tb_uart_cmd_rx;

  localparam int CPB = 8;
  localparam int TO  = 1500;

  logic        clk;
  logic        rst_n;
  logic        rx;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_req;
  logic [7:0]  rd_addr;
  logic        err;
  logic [7:0]  err_cnt;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t sb[$];
  cmd_t obs[$];
  int   err_pulses = 0;
  int   err_base;
  int   exp_err;
  int   n_checks = 0;
  int   n_pass   = 0;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_uart_rx (rx),
    .o_wr_en   (wr_en),
    .o_wr_addr (wr_addr),
    .o_wr_data (wr_data),
    .o_rd_req  (rd_req),
    .o_rd_addr (rd_addr),
    .o_err     (err),
    .o_err_cnt (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every strobe cycle and error pulse seen on the outputs
  always @(negedge clk) begin
    if (rst_n) begin
      if (err) err_pulses++;
      if (wr_en || rd_req) obs.push_back('{wr_en, wr_en ? wr_addr : rd_addr, wr_data});
    end
  end

  initial begin
    #(950000 * 1ns);
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic expect_cmd(input bit w, input logic [7:0] a, input logic [31:0] d);
    sb.push_back('{w, a, d});
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = bad_stop ? 1'b0 : 1'b1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b0);
  endtask

  task automatic drain(input string tag);
    cmd_t o, e;
    while (obs.size() > 0) begin
      o = obs.pop_front();
      if (sb.size() == 0) begin
        check({tag, "_unexpected_strobe"}, {24'd0, o.addr}, 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check({tag, "_kind"}, {31'd0, o.is_wr}, {31'd0, e.is_wr});
        check({tag, "_addr"}, {24'd0, o.addr}, {24'd0, e.addr});
        if (e.is_wr) check({tag, "_data"}, o.data, e.data);
      end
    end
    check({tag, "_missing_strobes"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic check_err(input string tag);
    check({tag, "_err_cnt"}, {24'd0, err_cnt}, (exp_err > 255) ? 32'd255 : 32'(exp_err));
    check({tag, "_err_pulses"}, 32'(err_pulses - err_base), 32'(exp_err));
  endtask

  initial begin
    rx = 1'b1;
    rst_n = 1'b0;
    exp_err = 0;
    repeat (5) @(negedge clk);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'd0);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_rd_req", {31'd0, rd_req}, 32'd0);
    check("rst_rd_addr", {24'd0, rd_addr}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    err_base = err_pulses;
    repeat (5) @(negedge clk);

    expect_cmd(1'b1, 8'h1A, 32'h0000BEEF);
    send_str("W1A0000BEEF\r");
    drain("write1");
    check_err("write1");

    expect_cmd(1'b0, 8'h05, 32'h0);
    send_str(" r05\n");
    drain("read05");

    send_str("W1G00000000\r");
    exp_err++;
    drain("badhex");
    check_err("badhex");
    expect_cmd(1'b1, 8'h02, 32'h12345678);
    send_str("w0212345678\r");
    drain("write2");

    send_byte(8'h52, 1'b1);
    exp_err++;
    check_err("framing");
    send_str("R10\r");
    drain("post_framing");
    expect_cmd(1'b0, 8'h10, 32'h0);
    send_str("R10\r");
    drain("read10");

    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    drain("glitch");
    check_err("glitch");

    send_str("R077\r");
    exp_err++;
    drain("extra_digit");
    check_err("extra_digit");

    send_str("W0A\n");
    exp_err++;
    drain("short_cmd");
    check_err("short_cmd");

    send_str("W12");
    repeat (TO + 500) @(negedge clk);
    exp_err++;
    check_err("timeout");
    expect_cmd(1'b0, 8'h33, 32'h0);
    send_str("R33\r");
    drain("read33");

    for (int i = 0; i < 300; i++) begin
      send_str("X\r");
      exp_err++;
    end
    drain("saturate");
    check_err("saturate");

    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_err_cnt", {24'd0, err_cnt}, 32'd0);
    rst_n = 1'b1;
    err_base = err_pulses;
    exp_err = 0;
    repeat (2 * CPB) @(negedge clk);
    expect_cmd(1'b0, 8'hA4, 32'h0);
    send_str("RA4\r");
    drain("after_reset");
    check_err("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
